// File: rtl/tetris_pkg.sv
// Shared colour codes, default playfield geometry and a width helper for the grid renderer.
package tetris_pkg;

  localparam int DEF_COLOR_W = 3;
  typedef logic [DEF_COLOR_W-1:0] color_t;

  localparam color_t BLACK = 3'b000;
  localparam color_t WHITE = 3'b111;

  localparam int COORD_W   = 10;
  localparam int DEF_COLS  = 10;
  localparam int DEF_ROWS  = 20;
  localparam int DEF_BLOCK = 15;
  localparam int DEF_X0    = 245;
  localparam int DEF_Y0    = 90;
  localparam int DEF_FLASH = 8;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tetris_grid_render_if.sv
// Raster-in / colour-out bundle plus the colour-map snapshot handshake of the grid renderer.
interface tetris_grid_render_if
  import tetris_pkg::*;
#(
  parameter int ROWS    = DEF_ROWS,
  parameter int COLS    = DEF_COLS,
  parameter int COLOR_W = DEF_COLOR_W
);
  logic [COORD_W-1:0]                        x;
  logic [COORD_W-1:0]                        y;
  logic                                      pix_valid;
  logic                                      frame_start;
  logic [ROWS-1:0][COLS-1:0][COLOR_W-1:0]    cell_color;
  logic                                      upd_valid;
  logic                                      upd_ack;
  logic [ROWS-1:0]                           flash_rows;
  logic [COLOR_W-1:0]                        shape_color;
  logic                                      out_valid;

  modport slave (
    input  x, y, pix_valid, frame_start, cell_color, upd_valid, flash_rows,
    output upd_ack, shape_color, out_valid
  );

  modport master (
    output x, y, pix_valid, frame_start, cell_color, upd_valid, flash_rows,
    input  upd_ack, shape_color, out_valid
  );
endinterface

// File: rtl/grid_axis_tracker.sv
// One-axis cell locator: sub-cell offset and cell index tracked incrementally from raster steps.
module grid_axis_tracker
  import tetris_pkg::*;
#(
  parameter int ORIGIN     = DEF_X0,
  parameter int BLOCK_SIZE = DEF_BLOCK,
  parameter int COUNT      = DEF_COLS,
  parameter int SUB_W      = idx_w(BLOCK_SIZE),
  parameter int IDX_W      = idx_w(COUNT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               advance,
  input  logic [COORD_W-1:0] coord,
  output logic [SUB_W-1:0]   sub,
  output logic [IDX_W-1:0]   idx
);
  localparam logic [COORD_W-1:0] LO = COORD_W'(ORIGIN);
  localparam logic [COORD_W-1:0] HI = COORD_W'(ORIGIN + COUNT * BLOCK_SIZE - 1);

  logic [SUB_W-1:0] sub_q, sub_nxt;
  logic [IDX_W-1:0] idx_q, idx_nxt;

  always_comb begin
    sub_nxt = sub_q;
    idx_nxt = idx_q;
    if (coord == LO) begin
      sub_nxt = '0;
      idx_nxt = '0;
    end else if (coord > LO && coord <= HI) begin
      if (sub_q == SUB_W'(BLOCK_SIZE - 1)) begin
        sub_nxt = '0;
        // Wrapping the index keeps a non-sequential raster from indexing past the map.
        idx_nxt = (idx_q == IDX_W'(COUNT - 1)) ? '0 : idx_q + IDX_W'(1);
      end else begin
        sub_nxt = sub_q + SUB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= '0;
      idx_q <= '0;
    end else if (advance) begin
      sub_q <= sub_nxt;
      idx_q <= idx_nxt;
    end
  end

  // The advancing pixel sees its own position; others see the last tracked one.
  assign sub = advance ? sub_nxt : sub_q;
  assign idx = advance ? idx_nxt : idx_q;
endmodule

// File: rtl/tetris_grid_render.sv
// Two-stage playfield renderer with tear-free colour-map snapshot; optional row flash under ROW_FLASH_EN.
module tetris_grid_render
  import tetris_pkg::*;
#(
  parameter int COLS         = DEF_COLS,
  parameter int ROWS         = DEF_ROWS,
  parameter int BLOCK_SIZE   = DEF_BLOCK,
  parameter int X0           = DEF_X0,
  parameter int Y0           = DEF_Y0,
  parameter int COLOR_W      = DEF_COLOR_W,
  parameter int FLASH_FRAMES = DEF_FLASH
) (
  input logic                  clk,
  input logic                  rst_n,
  tetris_grid_render_if.slave  bus
);
  localparam int COL_W = idx_w(COLS);
  localparam int ROW_W = idx_w(ROWS);
  localparam int SUB_W = idx_w(BLOCK_SIZE);
  localparam logic [COORD_W-1:0] X_LO = COORD_W'(X0);
  localparam logic [COORD_W-1:0] X_HI = COORD_W'(X0 + COLS * BLOCK_SIZE - 1);
  localparam logic [COORD_W-1:0] Y_LO = COORD_W'(Y0);
  localparam logic [COORD_W-1:0] Y_HI = COORD_W'(Y0 + ROWS * BLOCK_SIZE - 1);

  if (FLASH_FRAMES < 1 || BLOCK_SIZE < 2) begin : g_param_check
    $error("tetris_grid_render: FLASH_FRAMES must be >= 1 and BLOCK_SIZE >= 2");
  end

  logic [SUB_W-1:0] sub_x, sub_y;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             in_grid, on_line;

  grid_axis_tracker #(.ORIGIN(X0), .BLOCK_SIZE(BLOCK_SIZE), .COUNT(COLS)) u_x_axis (
    .clk(clk), .rst_n(rst_n), .advance(bus.pix_valid), .coord(bus.x), .sub(sub_x), .idx(col)
  );

  grid_axis_tracker #(.ORIGIN(Y0), .BLOCK_SIZE(BLOCK_SIZE), .COUNT(ROWS)) u_y_axis (
    .clk(clk), .rst_n(rst_n), .advance(bus.pix_valid && bus.x == X_LO), .coord(bus.y),
    .sub(sub_y), .idx(row)
  );

  assign in_grid = (bus.x >= X_LO) && (bus.x <= X_HI) && (bus.y >= Y_LO) && (bus.y <= Y_HI);
  assign on_line = (sub_x == '0) || (sub_y == '0) || (bus.x == X_HI) || (bus.y == Y_HI);

  logic [ROWS-1:0][COLS-1:0][COLOR_W-1:0] snap;
  logic                                   upd_ack_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap      <= '0;
      upd_ack_q <= 1'b0;
    end else begin
      upd_ack_q <= bus.frame_start && bus.upd_valid;
      if (bus.frame_start && bus.upd_valid) snap <= bus.cell_color;
    end
  end

`ifdef ROW_FLASH_EN
  localparam int FC_W = idx_w(FLASH_FRAMES);
  logic [FC_W-1:0] frame_cnt;
  logic            phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (bus.frame_start) begin
      if (frame_cnt == FC_W'(FLASH_FRAMES - 1)) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + FC_W'(1);
      end
    end
  end
`endif

  // Stage 1: grid membership, line flag and cell address
  logic             vld_p1, in_grid_p1, on_line_p1;
  logic [ROW_W-1:0] row_p1;
  logic [COL_W-1:0] col_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      in_grid_p1 <= 1'b0;
      on_line_p1 <= 1'b0;
      row_p1     <= '0;
      col_p1     <= '0;
    end else begin
      vld_p1 <= bus.pix_valid;
      if (bus.pix_valid) begin
        in_grid_p1 <= in_grid;
        on_line_p1 <= on_line;
        row_p1     <= row;
        col_p1     <= col;
      end
    end
  end

  // Stage 2: colour select
  logic [COLOR_W-1:0] color_nxt, color_p2;
  logic               vld_p2;

  always_comb begin
    color_nxt = snap[row_p1][col_p1];
    if (!in_grid_p1) begin
      color_nxt = COLOR_W'(BLACK);
    end else if (on_line_p1) begin
      color_nxt = COLOR_W'(WHITE);
`ifdef ROW_FLASH_EN
    end else if (phase && bus.flash_rows[row_p1]) begin
      color_nxt = COLOR_W'(WHITE);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2   <= 1'b0;
      color_p2 <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) color_p2 <= color_nxt;
    end
  end

  assign bus.shape_color = color_p2;
  assign bus.out_valid   = vld_p2;
  assign bus.upd_ack     = upd_ack_q;
endmodule

// File: tb/tb_tetris_grid_render.sv
// Directed bench for tetris_grid_render: sparse raster frames checked against a table of pixel colours.
module tb_tetris_grid_render;
  import tetris_pkg::*;

  localparam int X0 = 245;
  localparam int Y0 = 90;
  localparam int XL = 394;
  localparam int YL = 389;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tetris_grid_render_if #(.ROWS(20), .COLS(10), .COLOR_W(3)) bus ();

  tetris_grid_render #(
    .COLS(10), .ROWS(20), .BLOCK_SIZE(15), .X0(245), .Y0(90), .COLOR_W(3), .FLASH_FRAMES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    int         f;
    int         x;
    int         y;
    logic [2:0] c;
  } vec_t;

  vec_t       tbl[$];
  int         n_vec = 0;
  int         n_fail = 0;
  int         ack_cnt = 0;
  bit         lag_chk = 0;
  bit         prev_v = 0;
  bit         prev_chk = 0;
  logic [2:0] prev_exp = '0;
  int         prev_x = 0, prev_y = 0, cur_f = 0;
  logic [2:0] snap_m [20][10];

  task automatic add(input int f, input int xx, input int yy, input logic [2:0] c);
    vec_t v;
    v.f = f; v.x = xx; v.y = yy; v.c = c;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  function automatic logic [2:0] model(input int xx, input int yy);
    int sx, sy;
    if (xx < X0 || xx > XL || yy < Y0 || yy > YL) return 3'd0;
    sx = (xx - X0) % 15;
    sy = (yy - Y0) % 15;
    if (sx == 0 || sy == 0 || xx == XL || yy == YL) return 3'd7;
    return snap_m[(yy - Y0) / 15][(xx - X0) / 15];
  endfunction

  function automatic int find(input int f, input int xx, input int yy);
    foreach (tbl[i]) if (tbl[i].f == f && tbl[i].x == xx && tbl[i].y == yy) return i;
    return -1;
  endfunction

  // One clock: apply inputs, then judge the pixel that was applied one call earlier.
  task automatic step(input int xx, input int yy, input bit v, input bit chk, input logic [2:0] exp);
    bus.x = 10'(xx);
    bus.y = 10'(yy);
    bus.pix_valid = v;
    @(posedge clk);
    #1;
    if (bus.upd_ack === 1'b1) ack_cnt++;
    if (lag_chk) check("out_valid_lag", {31'd0, bus.out_valid}, {31'd0, prev_v});
    if (prev_chk) begin
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.shape_color !== prev_exp) begin
        n_fail++;
        $display("FAIL pix f%0d (%0d,%0d): got valid=%b color=%0d, want valid=1 color=%0d",
                 cur_f, prev_x, prev_y, bus.out_valid, bus.shape_color, prev_exp);
      end
    end
    prev_v   = v;
    prev_chk = v && chk;
    prev_exp = exp;
    prev_x   = xx;
    prev_y   = yy;
  endtask

  task automatic frame_pulse(input bit want_ack, input string name);
    bus.frame_start = 1'b1;
    step(0, 0, 0, 0, 3'd0);
    check({name, "_ack"}, {31'd0, bus.upd_ack}, {31'd0, want_ack});
    bus.frame_start = 1'b0;
    step(0, 0, 0, 0, 3'd0);
    check({name, "_ack_clear"}, {31'd0, bus.upd_ack}, 32'd0);
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_shape_color", {29'd0, bus.shape_color}, 32'd0);
    check("midrst_upd_ack", {31'd0, bus.upd_ack}, 32'd0);
    bus.pix_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    prev_v = 0;
    prev_chk = 0;
    foreach (snap_m[r, c]) snap_m[r][c] = 3'd0;
  endtask

  // Sparse raster: every line passes X0; lines carrying table points are widened to reach them.
  task automatic frame(input int f, input bit mid_change, input bit rst_at);
    int ys, ye, xs, xe, idx;
    cur_f = f;
    ys = Y0;
    ye = YL;
    foreach (tbl[i]) if (tbl[i].f == f) begin
      if (tbl[i].y < ys) ys = tbl[i].y;
      if (tbl[i].y > ye) ye = tbl[i].y;
    end
    for (int yy = ys; yy <= ye; yy++) begin
      if (mid_change && yy == 200) begin
        bus.cell_color[19][9] = 3'd5;
        bus.cell_color[7][3]  = 3'd6;
        bus.cell_color[0][0]  = 3'd3;
      end
      xs = X0;
      xe = X0;
      foreach (tbl[i]) if (tbl[i].f == f && tbl[i].y == yy) begin
        if (tbl[i].x < xs) xs = tbl[i].x;
        if (tbl[i].x > xe) xe = tbl[i].x;
      end
      if (rst_at && yy == 200 && xe < 300) xe = 300;
      for (int xx = xs; xx <= xe; xx++) begin
        idx = find(f, xx, yy);
        step(xx, yy, 1, idx >= 0, (idx >= 0) ? tbl[idx].c : 3'd0);
        if (rst_at && xx == 300 && yy == 200) begin
          mid_reset();
          return;
        end
      end
    end
    step(0, 0, 0, 0, 3'd0);
  endtask

  initial begin
    bus.x = '0; bus.y = '0; bus.pix_valid = 1'b0; bus.frame_start = 1'b0;
    bus.cell_color = '0; bus.upd_valid = 1'b0; bus.flash_rows = '0;
    foreach (snap_m[r, c]) snap_m[r][c] = 3'd0;

    // empty board
    add(0, 250, 95, 3'd0);  add(0, 245, 95, 3'd7);  add(0, 394, 200, 3'd7);
    add(0, 100, 100, 3'd0); add(0, 395, 200, 3'd0); add(0, 244, 95, 3'd0);
    add(0, 250, 89, 3'd0);  add(0, 250, 390, 3'd0); add(0, 250, 90, 3'd7);
    add(0, 394, 389, 3'd7);
    // first snapshot: [0][0]=4, [19][9]=2
    add(1, 250, 95, 3'd4);  add(1, 390, 385, 3'd2); add(1, 260, 95, 3'd7);
    add(1, 259, 95, 3'd4);  add(1, 261, 95, 3'd0);  add(1, 246, 91, 3'd4);
    add(1, 381, 376, 3'd2); add(1, 380, 376, 3'd7);
    // live map changed without a load: display unchanged
    add(2, 390, 385, 3'd2); add(2, 250, 95, 3'd4);  add(2, 300, 200, 3'd0);
    add(2, 381, 376, 3'd2);
    add(3, 390, 385, 3'd2); add(3, 300, 200, 3'd0);
    // second snapshot: [19][9]=5, [7][3]=6, [0][0]=3
    add(4, 390, 385, 3'd5); add(4, 250, 95, 3'd3);  add(4, 300, 200, 3'd6);
    add(4, 299, 200, 3'd6); add(4, 305, 200, 3'd7); add(4, 381, 376, 3'd5);
    add(5, 299, 200, 3'd6);
    // after mid-frame reset: cleared board
    add(6, 250, 95, 3'd0);  add(6, 390, 385, 3'd0); add(6, 300, 200, 3'd0);
    add(6, 245, 95, 3'd7);  add(6, 394, 200, 3'd7); add(6, 305, 200, 3'd7);

    for (int i = 0; i < 4; i++) begin
      step(X0 + i, Y0, 1, 0, 3'd0);
      check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    end
    check("reset_shape_color", {29'd0, bus.shape_color}, 32'd0);
    check("reset_upd_ack", {31'd0, bus.upd_ack}, 32'd0);
    bus.pix_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    prev_v = 0;
    prev_chk = 0;

    lag_chk = 1;
    frame(0, 0, 0);
    lag_chk = 0;

    bus.cell_color[0][0]  = 3'd4;
    bus.cell_color[19][9] = 3'd2;
    bus.upd_valid = 1'b1;
    frame_pulse(1, "load1");
    bus.upd_valid = 1'b0;
    snap_m[0][0] = 3'd4;
    snap_m[19][9] = 3'd2;
    frame(1, 0, 0);

    ack_cnt = 0;
    frame_pulse(0, "no_upd");
    frame(2, 1, 0);
    check("tear_free_ack_cnt", ack_cnt, 32'd0);
    bus.upd_valid = 1'b1;
    frame(3, 0, 0);
    check("upd_no_frame_ack_cnt", ack_cnt, 32'd0);
    frame_pulse(1, "load2");
    bus.upd_valid = 1'b0;
    snap_m[19][9] = 3'd5;
    snap_m[7][3]  = 3'd6;
    snap_m[0][0]  = 3'd3;
    frame(4, 0, 0);

    // stalled strobe on line Y0+1
    cur_f = 9;
    lag_chk = 1;
    step(X0, Y0, 1, 0, 3'd0);
    for (int xx = X0; xx <= X0 + 35; xx++) begin
      step(xx, Y0 + 1, 1, 1, model(xx, Y0 + 1));
      step(0, 0, 0, 0, 3'd0);
    end
    step(0, 0, 0, 0, 3'd0);
    lag_chk = 0;

    frame(5, 0, 1);
    frame(6, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
